par_engine: RTL and testbench
=============================

Name: par_engine

Overview:
- Parametrised parity generator/checker for the UART datapath; successor to the fixed 8-bit combinational parity calculator.
- TX side: registers a parity bit for a parallel word on Data_Valid.
- RX side: accumulates parity over a serial bitstream one sample strobe at a time, then checks the received parity bit.
- Supports even, odd, mark and space parity at any data width.

Parameters:
- DATA_WIDTH, 8, data bits per frame (legal range 5..16).
- CNT_W, $clog2(DATA_WIDTH), width of the RX bit counter (derived, not overridden).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- PAR_EN  in  1  parity enabled; 0 means frame has no parity bit.
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- Data_Valid  in  1  TX: P_DATA valid this cycle.
- P_DATA  in  DATA_WIDTH  TX parallel word.
- PAR_bit  out  1  TX registered parity bit.
- PAR_bit_vld  out  1  PAR_bit holds a valid result.
- Rx_Start  in  1  RX: start-bit detected; begins a new frame.
- Sample_Strb  in  1  RX: Sampled_Bit is valid this cycle.
- Sampled_Bit  in  1  RX serial bit, LSB first.
- Chk_Done  out  1  one-cycle pulse when the frame's parity phase completes.
- Par_Err  out  1  one-cycle pulse, coincident with Chk_Done, when parity mismatches.

Behaviour:
- Reset (RST=1 at a CLK edge): PAR_bit=0, PAR_bit_vld=0, Chk_Done=0, Par_Err=0. RX FSM goes to IDLE, accumulator=0, counter=0. Reset overrides every other input in that cycle.
- Parity function f(d, typ):
  - even: ^d
  - odd: ~^d
  - mark: 1
  - space: 0
- TX path:
  - Data_Valid=1, PAR_EN=1: next edge PAR_bit <= f(P_DATA, PAR_TYP) and PAR_bit_vld <= 1. Latency is 1 cycle.
  - Data_Valid=1, PAR_EN=0: PAR_bit <= 0, PAR_bit_vld <= 0.
  - Data_Valid=0: PAR_bit and PAR_bit_vld hold their value. PAR_TYP and P_DATA changes are ignored.
  - Back-to-back Data_Valid: each cycle's result overwrites the previous one.
- RX FSM states are IDLE, DATA and PAR.
  - Any state, Rx_Start=1: go to DATA, acc <= 0, cnt <= 0, latch PAR_EN/PAR_TYP into mode registers. A Sample_Strb in the same cycle is ignored (start wins). Rx_Start mid-frame aborts the frame silently; no Chk_Done.
  - IDLE: Sample_Strb is ignored.
  - DATA, on Sample_Strb: acc <= acc ^ Sampled_Bit, cnt <= cnt+1.
  - DATA, on the strobe where cnt == DATA_WIDTH-1: go to PAR if latched PAR_EN=1. Otherwise go to IDLE with Chk_Done=1 and Par_Err=0 on the next cycle.
  - PAR, on Sample_Strb: exp = f over the accumulated bits using the latched type. Next cycle Chk_Done=1 and Par_Err = (Sampled_Bit != exp). FSM returns to IDLE.
  - Chk_Done/Par_Err are registered, 1 cycle after the qualifying strobe, and high for exactly one cycle.
- TX and RX paths are independent; simultaneous activity on both is legal.
- Mode changes on PAR_EN/PAR_TYP during an RX frame do not affect that frame.

Optional Feature:
- Macro: PAR_ERR_CNT_EN.
- Defined:
  - Adds output Err_Cnt [7:0].
  - Increments on every Par_Err pulse and saturates at 255.
  - Cleared by RST only.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- TX, DATA_WIDTH=8, PAR_EN=1, Data_Valid pulse:
  - PAR_TYP=00, P_DATA=8'hA7 -> next cycle PAR_bit=1, PAR_bit_vld=1.
  - PAR_TYP=01, same data -> PAR_bit=0.
  - PAR_TYP=10 -> 1; PAR_TYP=11 -> 0.
- TX hold/disable: after the 8'hA7 even result, change P_DATA with Data_Valid=0 -> PAR_bit stays 1. Then Data_Valid with PAR_EN=0 -> PAR_bit=0, PAR_bit_vld=0.
- RX good frame, even parity: Rx_Start, strobe bits 1,1,1,0,0,1,0,1 (8'hA7 LSB first), then parity bit 1 -> Chk_Done=1, Par_Err=0 one cycle after the last strobe.
- RX bad frame, odd parity: same data, parity bit 1 -> Chk_Done=1, Par_Err=1. With PAR_ERR_CNT_EN, Err_Cnt goes 0->1; after 300 bad frames Err_Cnt=255.
- RX abort and no-parity: Rx_Start after 4 data bits restarts the frame with no Chk_Done. With PAR_EN=0, DATA_WIDTH=7: Chk_Done after the 7th strobe, Par_Err=0.
- Reset mid-frame: RST during PAR state -> FSM IDLE, all outputs 0, a following strobe is ignored. Rx_Start and Sample_Strb asserted together -> the strobe is not counted.

Source files
------------

// File: rtl/par_engine_if.sv
// Bus interface for par_engine: TX word/parity signals and the RX sample
// stream with its check results. The engine uses the slave modport, the
// agent that drives frames and words uses the master modport.
// The Err_Cnt member exists only when PAR_ERR_CNT_EN is defined.
interface par_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  PAR_EN;
  logic [1:0]            PAR_TYP;
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_bit;
  logic                  PAR_bit_vld;
  logic                  Rx_Start;
  logic                  Sample_Strb;
  logic                  Sampled_Bit;
  logic                  Chk_Done;
  logic                  Par_Err;
`ifdef PAR_ERR_CNT_EN
  logic [7:0]            Err_Cnt;
`endif

  modport master (
    output PAR_EN, PAR_TYP, Data_Valid, P_DATA, Rx_Start, Sample_Strb, Sampled_Bit,
    input  PAR_bit, PAR_bit_vld, Chk_Done, Par_Err
`ifdef PAR_ERR_CNT_EN
    , Err_Cnt
`endif
  );

  modport slave (
    input  PAR_EN, PAR_TYP, Data_Valid, P_DATA, Rx_Start, Sample_Strb, Sampled_Bit,
    output PAR_bit, PAR_bit_vld, Chk_Done, Par_Err
`ifdef PAR_ERR_CNT_EN
    , Err_Cnt
`endif
  );
endinterface

// File: rtl/par_engine.sv
// par_engine: parametrised UART parity generator (TX) and checker (RX).
// TX registers the parity of a parallel word one cycle after Data_Valid.
// RX folds a serial LSB-first bitstream into a running XOR, one bit per
// Sample_Strb, and compares the received parity bit against it.
// Parity types: 00 even, 01 odd, 10 mark, 11 space.
// Optional build macro PAR_ERR_CNT_EN adds an 8-bit saturating Err_Cnt.
module par_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  par_engine_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_t;

  // Parity for a given type, from the XOR-reduction of the data bits.
  function automatic logic par_fn(input logic xor_red, input logic [1:0] typ);
    logic p;
    case (typ)
      2'b00:   p = xor_red;
      2'b01:   p = ~xor_red;
      2'b10:   p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------- TX
  logic par_bit_p1;
  logic par_vld_p1;

  // TX result register: loads on Data_Valid, otherwise holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bit_p1 <= 1'b0;
      par_vld_p1 <= 1'b0;
    end else if (bus.Data_Valid) begin
      if (bus.PAR_EN) begin
        par_bit_p1 <= par_fn(^bus.P_DATA, bus.PAR_TYP);
        par_vld_p1 <= 1'b1;
      end else begin
        par_bit_p1 <= 1'b0;
        par_vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.PAR_bit     = par_bit_p1;
  assign bus.PAR_bit_vld = par_vld_p1;

  // ---------------------------------------------------------------- RX
  rx_state_t        state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [1:0]       typ_q, typ_d;
  logic             done_d, err_d;
  logic             chk_done_p1;
  logic             par_err_p1;

  // RX state, accumulator, counter, latched frame mode and result pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      typ_q       <= 2'b00;
      chk_done_p1 <= 1'b0;
      par_err_p1  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      typ_q       <= typ_d;
      chk_done_p1 <= done_d;
      par_err_p1  <= err_d;
    end
  end

  // RX next-state: Rx_Start wins over a same-cycle strobe and aborts any
  // frame in flight; the frame mode is frozen at start.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    typ_d   = typ_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.Rx_Start) begin
      state_d = DATA;
      acc_d   = 1'b0;
      cnt_d   = '0;
      en_d    = bus.PAR_EN;
      typ_d   = bus.PAR_TYP;
    end else if (bus.Sample_Strb) begin
      case (state_q)
        DATA: begin
          acc_d = acc_q ^ bus.Sampled_Bit;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (en_q) begin
              state_d = PAR;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        PAR: begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (bus.Sampled_Bit != par_fn(acc_q, typ_q));
        end
        default: ;
      endcase
    end
  end

  assign bus.Chk_Done = chk_done_p1;
  assign bus.Par_Err  = par_err_p1;

`ifdef PAR_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of parity errors; only RST clears it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.Err_Cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_par_engine.sv
// Self-checking bench for par_engine: an 8-bit instance carries all tests,
// a 7-bit instance shares the same stimulus for the odd-width frame check.
module tb_par_engine;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   err_model = 0;

  always #5 clk = ~clk;

  par_engine_if #(.DATA_WIDTH(8)) bus8 ();
  par_engine_if #(.DATA_WIDTH(7)) bus7 ();

  assign bus7.PAR_EN      = bus8.PAR_EN;
  assign bus7.PAR_TYP     = bus8.PAR_TYP;
  assign bus7.Data_Valid  = bus8.Data_Valid;
  assign bus7.P_DATA      = bus8.P_DATA[6:0];
  assign bus7.Rx_Start    = bus8.Rx_Start;
  assign bus7.Sample_Strb = bus8.Sample_Strb;
  assign bus7.Sampled_Bit = bus8.Sampled_Bit;

  par_engine #(.DATA_WIDTH(8)) dut8 (.CLK(clk), .RST(rst), .bus(bus8));
  par_engine #(.DATA_WIDTH(7)) dut7 (.CLK(clk), .RST(rst), .bus(bus7));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference parity from the count of ones in the word.
  function automatic logic ref_par(input int ones, input logic [1:0] typ);
    case (typ)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One RX frame: start, nbits data strobes, optional parity strobe; checks
  // that no Chk_Done appears early, then the done/error pulse and its end.
  task automatic rx_frame(input logic [15:0] data, input int nbits, input logic en,
                          input logic [1:0] typ, input logic pbit, input bit w7,
                          input bit gaps);
    logic exp_err;
    logic od, oe;
    bus8.Rx_Start = 1'b1; bus8.PAR_EN = en; bus8.PAR_TYP = typ; bus8.Sample_Strb = 1'b0;
    tick();
    bus8.Rx_Start = 1'b0;
    for (int i = 0; i <= nbits; i++) begin
      if (i == nbits && !en) break;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus8.PAR_EN = 1'($urandom); bus8.PAR_TYP = 2'($urandom);
          bus8.Sampled_Bit = 1'($urandom);
          tick();
        end
      end
      bus8.Sample_Strb = 1'b1;
      bus8.Sampled_Bit = (i == nbits) ? pbit : data[i];
      bus8.PAR_EN = 1'($urandom); bus8.PAR_TYP = 2'($urandom);
      tick();
      bus8.Sample_Strb = 1'b0;
      od = w7 ? bus7.Chk_Done : bus8.Chk_Done;
      if (!((i == nbits) || (i == nbits - 1 && !en))) begin
        vectors++;
        if (od !== 1'b0) begin
          miscompares++;
          $display("FAIL rx_early_done bit=%0d got=%b want=0", i, od);
        end
      end
    end
    exp_err = en ? (pbit != ref_par($countones(data & 16'((1 << nbits) - 1)), typ)) : 1'b0;
    od = w7 ? bus7.Chk_Done : bus8.Chk_Done;
    oe = w7 ? bus7.Par_Err : bus8.Par_Err;
    vectors++;
    if (od !== 1'b1 || oe !== exp_err) begin
      miscompares++;
      $display("FAIL rx_done data=%h done=%b err=%b want done=1 err=%b", data, od, oe, exp_err);
    end
    if (!w7 && exp_err && err_model < 255) err_model++;
    tick();
    od = w7 ? bus7.Chk_Done : bus8.Chk_Done;
    oe = w7 ? bus7.Par_Err : bus8.Par_Err;
    vectors++;
    if (od !== 1'b0 || oe !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_pulse_len done=%b err=%b want 0/0", od, oe);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.Data_Valid = 1'b1; bus8.PAR_EN = 1'b1; bus8.PAR_TYP = 2'b00; bus8.P_DATA = 8'hA7;
    bus8.Rx_Start = 1'b1; bus8.Sample_Strb = 1'b0; bus8.Sampled_Bit = 1'b0;
    tick(); tick();
    err_model = 0;
    vectors++;
    if (bus8.PAR_bit !== 1'b0 || bus8.PAR_bit_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tx bit=%b vld=%b want 0/0", bus8.PAR_bit, bus8.PAR_bit_vld);
    end
    vectors++;
    if (bus8.Chk_Done !== 1'b0 || bus8.Par_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rx done=%b err=%b want 0/0", bus8.Chk_Done, bus8.Par_Err);
    end
`ifdef PAR_ERR_CNT_EN
    vectors++;
    if (bus8.Err_Cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_errcnt got=%0d want=0", bus8.Err_Cnt);
    end
`endif
    bus8.Data_Valid = 1'b0; bus8.Rx_Start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_tx_modes();
    logic [3:0] want;
    want = 4'b0101;
    for (int t = 0; t < 4; t++) begin
      bus8.Data_Valid = 1'b1; bus8.PAR_EN = 1'b1; bus8.PAR_TYP = t[1:0]; bus8.P_DATA = 8'hA7;
      tick();
      bus8.Data_Valid = 1'b0;
      vectors++;
      if (bus8.PAR_bit !== want[t] || bus8.PAR_bit_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL tx_mode typ=%0d bit=%b vld=%b want %b/1", t, bus8.PAR_bit,
                 bus8.PAR_bit_vld, want[t]);
      end
    end
  endtask

  task automatic test_tx_hold();
    bus8.Data_Valid = 1'b1; bus8.PAR_EN = 1'b1; bus8.PAR_TYP = 2'b00; bus8.P_DATA = 8'hA7;
    tick();
    bus8.Data_Valid = 1'b0; bus8.P_DATA = 8'h01; bus8.PAR_TYP = 2'b01;
    tick(); tick();
    vectors++;
    if (bus8.PAR_bit !== 1'b1 || bus8.PAR_bit_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_hold bit=%b vld=%b want 1/1", bus8.PAR_bit, bus8.PAR_bit_vld);
    end
    bus8.Data_Valid = 1'b1; bus8.PAR_EN = 1'b0;
    tick();
    bus8.Data_Valid = 1'b0;
    vectors++;
    if (bus8.PAR_bit !== 1'b0 || bus8.PAR_bit_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_disable bit=%b vld=%b want 0/0", bus8.PAR_bit, bus8.PAR_bit_vld);
    end
  endtask

  task automatic test_tx_random();
    logic exp_bit, exp_vld;
    exp_bit = 1'b0; exp_vld = 1'b0;
    for (int n = 0; n < 60; n++) begin
      bus8.Data_Valid = 1'($urandom_range(0, 1));
      bus8.PAR_EN = ($urandom_range(0, 3) != 0);
      bus8.PAR_TYP = 2'($urandom);
      bus8.P_DATA = 8'($urandom);
      if (bus8.Data_Valid) begin
        exp_vld = bus8.PAR_EN;
        exp_bit = bus8.PAR_EN ? ref_par($countones(bus8.P_DATA), bus8.PAR_TYP) : 1'b0;
      end
      tick();
      vectors++;
      if (bus8.PAR_bit !== exp_bit || bus8.PAR_bit_vld !== exp_vld) begin
        miscompares++;
        $display("FAIL tx_random n=%0d bit=%b vld=%b want %b/%b", n, bus8.PAR_bit,
                 bus8.PAR_bit_vld, exp_bit, exp_vld);
      end
    end
    bus8.Data_Valid = 1'b0;
  endtask

  task automatic test_rx_directed();
    rx_frame(16'h00A7, 8, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    rx_frame(16'h00A7, 8, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_rx_random();
    for (int n = 0; n < 30; n++) begin
      rx_frame(16'($urandom_range(0, 255)), 8, ($urandom_range(0, 4) != 0),
               2'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
  endtask

  task automatic test_abort_and_width7();
    bus8.Rx_Start = 1'b1; bus8.PAR_EN = 1'b1; bus8.PAR_TYP = 2'b00;
    tick();
    bus8.Rx_Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus8.Sample_Strb = 1'b1; bus8.Sampled_Bit = 1'($urandom);
      tick();
    end
    bus8.Sample_Strb = 1'b0;
    rx_frame(16'h00A7, 8, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    rx_frame(16'h0055, 7, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    rx_frame(16'h0013, 7, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hA7;
    bus8.Data_Valid = 1'b1; bus8.PAR_EN = 1'b1; bus8.PAR_TYP = 2'b00; bus8.P_DATA = d;
    bus8.Rx_Start = 1'b1;
    tick();
    bus8.Data_Valid = 1'b0; bus8.Rx_Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.Sample_Strb = 1'b1; bus8.Sampled_Bit = d[i];
      tick();
    end
    rst = 1'b1; bus8.Sampled_Bit = 1'b0;
    tick();
    rst = 1'b0; bus8.Sample_Strb = 1'b0;
    err_model = 0;
    vectors++;
    if (bus8.PAR_bit !== 1'b0 || bus8.PAR_bit_vld !== 1'b0 ||
        bus8.Chk_Done !== 1'b0 || bus8.Par_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset bit=%b vld=%b done=%b err=%b want all 0", bus8.PAR_bit,
               bus8.PAR_bit_vld, bus8.Chk_Done, bus8.Par_Err);
    end
    bus8.Sample_Strb = 1'b1; bus8.Sampled_Bit = 1'b0;
    tick();
    bus8.Sample_Strb = 1'b0;
    vectors++;
    if (bus8.Chk_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_strobe done=%b want 0", bus8.Chk_Done);
    end
    // start and strobe together: the strobe must not count as a data bit
    bus8.Rx_Start = 1'b1; bus8.Sample_Strb = 1'b1; bus8.Sampled_Bit = 1'b1;
    tick();
    bus8.Rx_Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.Sampled_Bit = d[i];
      tick();
    end
    bus8.Sample_Strb = 1'b0;
    vectors++;
    if (bus8.Chk_Done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_strobe_counted done=%b want 0", bus8.Chk_Done);
    end
    bus8.Sample_Strb = 1'b1; bus8.Sampled_Bit = 1'b1;
    tick();
    bus8.Sample_Strb = 1'b0;
    vectors++;
    if (bus8.Chk_Done !== 1'b1 || bus8.Par_Err !== 1'b0) begin
      miscompares++;
      $display("FAIL start_strobe_frame done=%b err=%b want 1/0", bus8.Chk_Done, bus8.Par_Err);
    end
    tick();
  endtask

`ifdef PAR_ERR_CNT_EN
  task automatic test_err_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    err_model = 0;
    rx_frame(16'h00A7, 8, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus8.Err_Cnt !== 8'(err_model) || err_model != 1) begin
      miscompares++;
      $display("FAIL errcnt_first got=%0d want=1", bus8.Err_Cnt);
    end
    for (int n = 0; n < 299; n++) rx_frame(16'h00A7, 8, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus8.Err_Cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL errcnt_saturate got=%0d want=255", bus8.Err_Cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus8.PAR_EN = 1'b0; bus8.PAR_TYP = 2'b00; bus8.Data_Valid = 1'b0; bus8.P_DATA = 8'h00;
    bus8.Rx_Start = 1'b0; bus8.Sample_Strb = 1'b0; bus8.Sampled_Bit = 1'b0;
    test_reset();
    test_tx_modes();
    test_tx_hold();
    test_tx_random();
    test_rx_directed();
    test_rx_random();
    test_abort_and_width7();
    test_reset_mid_frame();
`ifdef PAR_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
